// File: rtl/apb_uart_rx_poller.sv
// apb_uart_rx_poller: APB master that configures the UART receiver, then polls it and drains bytes/errors.
module apb_uart_rx_poller #(
  parameter int POLL_GAP   = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [13:0]           cfg_bit_period,
  input  logic [3:0]            cfg_data_size,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  psel,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  input  logic                  byte_ready,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic                  bus_error
);
  typedef enum logic [3:0] {IDLE, CFG0, CFG1, CFG2, POLL, ERRRD, DATARD, DELIVER, GAP} state_t;
  state_t state, nxt, nat, gap_st;
  logic ph, bnd, apb, acc, is_cfg, st, sp, err_ev;
  logic pend_start, pend_stop;
  logic [13:0] bp, pend_bp;
  logic [3:0] ds, pend_ds;
  logic [7:0] cnt;
  assign apb = state inside {CFG0, CFG1, CFG2, POLL, ERRRD, DATARD};
  assign is_cfg = state inside {CFG0, CFG1, CFG2};
  assign acc = apb && ph;
  assign st = cfg_start || pend_start;
  assign sp = cfg_stop || pend_stop;
  assign gap_st = (POLL_GAP == 0) ? POLL : GAP;
  assign err_ev = acc && state == ERRRD && !pslverr && |prdata[1:0];
  // bnd marks cycles where a pending start/stop may redirect the FSM: end of ACCESS, accepted delivery, any GAP cycle
  always_comb begin
    nat = IDLE;
    bnd = 1'b1;
    case (state)
      CFG0:    begin bnd = ph; nat = pslverr ? IDLE : CFG1; end
      CFG1:    begin bnd = ph; nat = pslverr ? IDLE : CFG2; end
      CFG2:    begin bnd = ph; nat = pslverr ? IDLE : POLL; end
      POLL:    begin bnd = ph; nat = (pslverr || !prdata[0]) ? gap_st : ERRRD; end
      ERRRD:   begin bnd = ph; nat = pslverr ? gap_st : DATARD; end
      DATARD:  begin bnd = ph; nat = pslverr ? gap_st : DELIVER; end
      DELIVER: begin bnd = byte_ready; nat = gap_st; end
      GAP:     nat = (cnt == 8'(POLL_GAP - 1)) ? POLL : GAP;
      default: nat = IDLE;
    endcase
    nxt = !bnd ? state : (st ? CFG0 : (sp ? IDLE : nat));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ph    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      ph    <= apb && !ph;
      cnt   <= (state == GAP && nxt == GAP) ? cnt + 8'd1 : '0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_start <= 1'b0;
      pend_stop  <= 1'b0;
      pend_bp    <= '0;
      pend_ds    <= '0;
      bp         <= '0;
      ds         <= '0;
      cfg_done   <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      byte_data  <= '0;
      bus_error  <= 1'b0;
    end else begin
      pend_start <= !bnd && st;
      pend_stop  <= !bnd && sp;
      if (cfg_start) begin
        pend_bp <= cfg_bit_period;
        pend_ds <= cfg_data_size;
      end
      if (bnd && st) begin
        bp <= cfg_start ? cfg_bit_period : pend_bp;
        ds <= cfg_start ? cfg_data_size : pend_ds;
      end
      cfg_done  <= acc && state == CFG2 && !pslverr;
      err_valid <= err_ev;
      if (err_ev) err_code <= prdata[1:0];
      if (acc && state == DATARD && !pslverr) byte_data <= prdata[7:0];
      bus_error <= (acc && pslverr) || (bus_error && !cfg_start);
    end
  assign busy = state != IDLE;
  assign psel = apb;
  assign penable = acc;
  assign pwrite = is_cfg;
  assign byte_valid = state == DELIVER;
  assign paddr = state == CFG0   ? ADDR_WIDTH'(2) :
                 state == CFG1   ? ADDR_WIDTH'(3) :
                 state == CFG2   ? ADDR_WIDTH'(4) :
                 state == ERRRD  ? ADDR_WIDTH'(1) :
                 state == DATARD ? ADDR_WIDTH'(6) : ADDR_WIDTH'(0);
  assign pwdata = state == CFG0 ? DATA_WIDTH'(bp[7:0]) :
                  state == CFG1 ? DATA_WIDTH'({2'b00, bp[13:8]}) :
                  state == CFG2 ? DATA_WIDTH'({4'h0, ds}) : '0;
endmodule

// File: tb/tb_apb_uart_rx_poller.sv
// tb_apb_uart_rx_poller: behavioural UART-receiver slave plus byte/error scoreboard around the poller.
module tb_apb_uart_rx_poller;
  localparam int GAP = 4;
  logic tb_clk = 1'b0, rst = 1'b1;
  logic cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [13:0] cfg_bit_period = '0;
  logic [3:0] cfg_data_size = '0;
  logic busy, cfg_done, psel, penable, pwrite, pslverr;
  logic [2:0] paddr;
  logic [7:0] pwdata, prdata;
  logic byte_valid, err_valid, bus_error;
  logic byte_ready = 1'b1;
  logic [7:0] byte_data;
  logic [1:0] err_code;
  logic rx_ready, rx_fe, rx_ovr;
  logic [7:0] rx_data;
  logic [3:0] slv_size;
  logic arr_pulse = 1'b0, arr_fe = 1'b0, inj_err = 1'b0;
  logic [7:0] arr_data = '0;
  logic [10:0] cfg_log [$];
  logic [7:0] exp_bytes [$];
  logic [1:0] exp_errs [$];
  int n_checks = 0, n_fail = 0, cyc = 0, done_cnt = 0;
  logic [3:0] cur_size = 4'd8;
  logic hold = 1'b0, prev_setup = 1'b0;
  logic [7:0] hold_d = '0;
  logic [2:0] prev_addr = '0;

  apb_uart_rx_poller #(.POLL_GAP(GAP), .ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(tb_clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_bit_period(cfg_bit_period), .cfg_data_size(cfg_data_size), .busy(busy), .cfg_done(cfg_done),
    .psel(psel), .paddr(paddr), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .err_valid(err_valid), .err_code(err_code), .bus_error(bus_error));

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc++;

  function automatic logic [7:0] msk(input logic [3:0] s);
    logic [8:0] m;
    m = (9'd1 << s) - 9'd1;
    return m[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // receiver slave: status read-to-clear, data read clears ready, a new frame over unread data flags overrun
  assign pslverr = inj_err && psel && penable && pwrite && paddr == 3'd3;
  assign prdata = paddr == 3'd0 ? {7'b0, rx_ready} :
                  paddr == 3'd1 ? {6'b0, rx_ovr, rx_fe} :
                  paddr == 3'd6 ? rx_data : 8'h00;
  always @(posedge tb_clk or posedge rst)
    if (rst) begin
      rx_ready <= 1'b0; rx_fe <= 1'b0; rx_ovr <= 1'b0; rx_data <= '0; slv_size <= 4'd8;
    end else begin
      if (psel && penable) begin
        if (pwrite) begin
          cfg_log.push_back({paddr, pwdata});
          if (paddr == 3'd4 && !pslverr) slv_size <= pwdata[3:0];
        end else if (paddr == 3'd1) begin
          rx_fe <= 1'b0; rx_ovr <= 1'b0;
        end else if (paddr == 3'd6) rx_ready <= 1'b0;
      end
      if (arr_pulse) begin
        rx_ready <= 1'b1;
        rx_data <= arr_data & msk(slv_size);
        rx_fe <= arr_fe;
        if (rx_ready) rx_ovr <= 1'b1;
      end
    end

  always @(negedge tb_clk) begin
    logic [8:0] eb;
    logic [2:0] ee;
    #1;
    if (rst) begin
      hold = 1'b0; prev_setup = 1'b0;
    end else begin
      if (hold) check("hold", {byte_valid, byte_data}, {1'b1, hold_d});
      hold = byte_valid && !byte_ready;
      hold_d = byte_data;
      if (byte_valid && byte_ready) begin
        eb = exp_bytes.size() > 0 ? {1'b0, exp_bytes.pop_front()} : 9'h100;
        check("byte_data", {1'b0, byte_data}, eb);
      end
      if (err_valid) begin
        ee = exp_errs.size() > 0 ? {1'b0, exp_errs.pop_front()} : 3'b100;
        check("err_code", {1'b0, err_code}, ee);
      end
      if (penable) check("apb_access", {prev_setup, prev_addr}, {1'b1, paddr});
      prev_setup = psel && !penable;
      prev_addr = paddr;
      if (cfg_done) done_cnt++;
    end
  end

  task automatic cfg(input logic [13:0] bp, input logic [3:0] sz);
    @(negedge tb_clk);
    cfg_bit_period = bp; cfg_data_size = sz; cfg_start = 1'b1;
    @(negedge tb_clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt <= d0 && k < 100) begin @(negedge tb_clk); k++; end
    check("cfg_done_seen", done_cnt, d0 + 1);
  endtask

  task automatic check_log(input logic [13:0] bp, input logic [3:0] sz);
    logic [10:0] e [3];
    e[0] = {3'd2, bp[7:0]};
    e[1] = {3'd3, 2'b00, bp[13:8]};
    e[2] = {3'd4, 4'h0, sz};
    check("cfg_count", cfg_log.size(), 3);
    if (cfg_log.size() == 3) for (int i = 0; i < 3; i++) check("cfg_write", cfg_log[i], e[i]);
  endtask

  task automatic send(input logic [7:0] d, input logic fe);
    @(negedge tb_clk);
    arr_data = d; arr_fe = fe; arr_pulse = 1'b1;
    @(negedge tb_clk);
    arr_pulse = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int lim);
    int k = 0;
    while ((exp_bytes.size() > 0 || exp_errs.size() > 0) && k < lim) begin
      @(negedge tb_clk);
      if (rnd) byte_ready = 1'($urandom_range(0, 1));
      k++;
    end
    byte_ready = 1'b1;
    check("drain_bytes", exp_bytes.size(), 0);
    check("drain_errs", exp_errs.size(), 0);
  endtask

  task automatic frame(input logic [7:0] d, input logic fe, input bit rnd);
    exp_bytes.push_back(d & msk(cur_size));
    if (fe) exp_errs.push_back(2'b01);
    send(d, fe);
    drain(rnd, 500);
    @(negedge tb_clk);
    check("rx_ready_clr", rx_ready, 0);
  endtask

  task automatic wait_poll(output int c);
    int k = 0;
    do begin @(negedge tb_clk); k++; end while (!(psel && !penable && paddr == 3'd0) && k < 200);
    c = cyc;
  endtask

  initial begin
    logic [14:0] seq [7];
    int c1, c2, d0, k, pc;
    logic [13:0] bp;
    logic [7:0] a, b, c;
    seq = '{{3'b101, 3'd2, 1'b0, 8'h0A}, {3'b111, 3'd2, 1'b0, 8'h0A},
            {3'b101, 3'd3, 1'b0, 8'h00}, {3'b111, 3'd3, 1'b0, 8'h00},
            {3'b101, 3'd4, 1'b0, 8'h08}, {3'b111, 3'd4, 1'b0, 8'h08},
            {3'b100, 3'd0, 1'b1, 8'h00}};
    repeat (3) @(negedge tb_clk);
    check("reset_out", {busy, cfg_done, psel, penable, pwrite, paddr, pwdata, byte_valid,
                        byte_data, err_valid, err_code, bus_error}, 0);
    rst = 1'b0;
    cfg_log.delete();
    cfg(14'd10, 4'd8);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge tb_clk);
      check("cfg_seq", {psel, penable, pwrite, paddr, cfg_done, pwrite ? pwdata : 8'h00}, seq[i]);
    end
    check("cfg_busy", busy, 1);
    check_log(14'd10, 4'd8);
    wait_poll(c1);
    wait_poll(c2);
    check("poll_period", c2 - c1, 2 + GAP);
    frame(8'hD5, 1'b0, 1'b0);
    frame(8'hD5, 1'b1, 1'b0);
    repeat (12) begin
      frame(8'($urandom), $urandom_range(0, 3) == 0, 1'b1);
      repeat ($urandom_range(0, 10)) @(negedge tb_clk);
    end
    bp = 14'($urandom_range(1, 16383));
    cfg_log.delete();
    d0 = done_cnt;
    cfg(bp, 4'd8);
    wait_done(d0);
    check_log(bp, 4'd8);
    byte_ready = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    exp_bytes.push_back(a);
    send(a, 1'b0);
    k = 0;
    while (!byte_valid && k < 200) begin @(negedge tb_clk); k++; end
    check("stall_first", {byte_valid, byte_data}, {1'b1, a});
    send(b, 1'b0);
    send(c, 1'b0);
    exp_bytes.push_back(c);
    exp_errs.push_back(2'b10);
    repeat (8) @(negedge tb_clk);
    check("stall_held", {byte_valid, byte_data}, {1'b1, a});
    byte_ready = 1'b1;
    drain(1'b0, 500);
    cfg_log.delete();
    d0 = done_cnt;
    cfg(14'd10, 4'd5);
    cur_size = 4'd5;
    wait_done(d0);
    check_log(14'd10, 4'd5);
    frame(8'h15, 1'b0, 1'b0);
    frame(8'($urandom), 1'b0, 1'b0);
    k = 0;
    while (!(busy && !psel && !byte_valid) && k < 50) begin @(negedge tb_clk); k++; end
    cfg_stop = 1'b1;
    @(negedge tb_clk);
    cfg_stop = 1'b0;
    check("stop_busy", busy, 0);
    pc = 0;
    repeat (20) begin @(negedge tb_clk); pc += int'(psel); end
    check("stop_quiet", pc, 0);
    inj_err = 1'b1;
    d0 = done_cnt;
    cfg(14'd10, 4'd8);
    cur_size = 4'd8;
    repeat (10) @(negedge tb_clk);
    check("slverr_state", {bus_error, busy}, 2'b10);
    check("slverr_no_done", done_cnt, d0);
    inj_err = 1'b0;
    cfg_log.delete();
    cfg(14'd10, 4'd8);
    check("bus_error_clr", bus_error, 0);
    wait_done(d0);
    check_log(14'd10, 4'd8);
    k = 0;
    while (!psel && k < 50) begin @(negedge tb_clk); k++; end
    rst = 1'b1;
    #1;
    check("rst_psel", {psel, busy}, 0);
    @(negedge tb_clk);
    rst = 1'b0;
    repeat (2) @(negedge tb_clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_uart_rx_poller.md
Name: apb_uart_rx_poller

Overview:
- APB master controller that sequences the APB-attached UART receiver (apb_slave + rcv_block) with no software involvement.
- On command it programs the bit-period and data-size configuration registers.
- It then polls the status registers continuously. Each received byte is drained to a ready/valid consumer port, and line errors are reported as one-cycle events.
- It sits between a system controller and the receiver's APB slave port, replacing the bus model used in bench bring-up.

Parameters:
- POLL_GAP, 4, idle cycles between consecutive status polls (legal range 0..255).
- ADDR_WIDTH, 3, APB address width.
- DATA_WIDTH, 8, APB data width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  pulse: latch cfg_* and (re)program the receiver.
- cfg_stop  in  1  pulse: stop polling after the current APB transfer.
- cfg_bit_period  in  14  clocks per UART bit.
- cfg_data_size  in  4  data bits per frame (5..8).
- busy  out  1  controller not in IDLE.
- cfg_done  out  1  one-cycle pulse after the third config write completes.
- psel  out  1  APB select.
- paddr  out  ADDR_WIDTH  APB address.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pslverr  in  1  APB slave error.
- byte_valid  out  1  received byte available.
- byte_data  out  8  received byte.
- byte_ready  in  1  consumer accepts byte.
- err_valid  out  1  one-cycle error event.
- err_code  out  2  bit0 framing, bit1 overrun.
- bus_error  out  1  sticky: a transfer saw pslverr.

Behaviour:
- Register map: 0 data status (bit0 = data ready), 1 error status, 2 bit period [7:0], 3 bit period {2'b00, [13:8]}, 4 data size {4'b0, size}, 6 rx data.
- Reset value of every output is 0. Reset returns the FSM to IDLE and clears all latches. A reset mid-transfer drops psel immediately.
- APB transfer timing, every transfer exactly 2 cycles:
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1; prdata and pslverr are sampled at the end of ACCESS.
  - psel=0 between transfers. Zero-wait slave; there is no pready.
- FSM states: IDLE, CFG0, CFG1, CFG2, POLL, ERRRD, DATARD, DELIVER, GAP.
- IDLE: cfg_start latches cfg_bit_period and cfg_data_size. SETUP of CFG0 is driven on the next cycle.
- CFG0 -> CFG1 -> CFG2: writes to addr 2, 3, 4 in order.
  - If no error, cfg_done pulses in the cycle after CFG2 ACCESS; SETUP of POLL is driven in that same cycle.
  - Latency: cfg_start sampled at edge N gives cfg_done high in cycle N+7.
- POLL: read addr 0.
  - prdata[0]=0 -> GAP.
  - prdata[0]=1 -> ERRRD.
- ERRRD: read addr 1.
  - If prdata[1:0] != 0: err_valid=1 for one cycle with err_code=prdata[1:0], then DATARD.
  - If prdata[1:0] == 0: go to DATARD with no event.
- DATARD: read addr 6. This read produces data_read in the slave, which clears data ready. Latch prdata into byte_data, then DELIVER.
- A byte is delivered even when its frame had a framing error.
- DELIVER: byte_valid=1 and byte_data held stable until a cycle with byte_ready=1; then byte_valid drops and the FSM goes to GAP. No APB traffic while in DELIVER, so a stalled consumer causes receiver overrun, which is reported on the next poll.
- GAP: count POLL_GAP idle cycles, then POLL. POLL_GAP=0 means POLL SETUP immediately follows.
- cfg_stop (any non-IDLE state): latched as pending; the FSM enters IDLE after the current APB transfer or current delivery completes.
- cfg_start while busy: latched as pending; after the current transfer/delivery, restart at CFG0 with the newly latched values. cfg_start outranks cfg_stop when both are pending.
- pslverr:
  - Sets bus_error; the transfer is not retried.
  - In CFG states: abort to IDLE; cfg_done is not pulsed.
  - In POLL/ERRRD/DATARD: treat the read as "nothing" and go to GAP.
  - bus_error clears only on the next cfg_start or on reset.
- busy=1 in every state except IDLE.

Test Plan:
- Configure with bit_period=10, size=8 -> writes 0x0A@2, 0x00@3, 0x08@4 in 6 consecutive cycles; cfg_done pulse in cycle 7; polling starts.
- Send 0xD5 with a good stop bit, byte_ready=1 -> one byte_valid pulse with byte_data=0xD5, no err_valid, rcv data_ready returns to 0.
- Send 0xD5 with stop bit 0 -> err_valid pulse with err_code=2'b01; byte still delivered.
- Hold byte_ready=0 while two frames arrive -> byte_valid held with the first byte; after release, the next poll reports err_code=2'b10 (overrun).
- size=5, data 0x15, bit_period=10 -> byte_data=0x15; cfg_stop during GAP -> IDLE, busy=0, no further psel.
- Force pslverr on the CFG1 write -> bus_error=1, FSM in IDLE, no cfg_done; a subsequent cfg_start clears bus_error.
